bus_access_controller: RTL

//  Sequences and shares the external 16-bit bidirectional data bus between two requesters
//  (0 = voice engine, 1 = control/config path). Owns the tri-state driver's nWRITE and DataIn
//  and reads its DataOut. Generates chip-select, strobes and address for the external device.

---
 rtl/bus_access_controller_if.sv | 36 +++
 rtl/bus_access_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bus_access_controller_if.sv
// Bus bundle between the requesters / tri-state driver and bus_access_controller.
// Handshake: a requester raises Req[i] and holds it (with Wr/Addr/WData) until it
// sees the one-cycle Done[i] pulse; the request is taken on the grant edge, later
// changes to Wr/Addr/WData are ignored until the next grant.
interface bus_access_controller_if #(
  parameter int ADDR_W = 16
) ();
  logic [1:0]        Req;
  logic [1:0]        Wr;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [15:0]       WData0;
  logic [15:0]       WData1;
  logic [1:0]        Done;
  logic [15:0]       RData;
  logic              Busy;
  logic              nWRITE;
  logic [15:0]       DrvData;
  logic [15:0]       BusData;
  logic [ADDR_W-1:0] ExtAddr;
  logic              nCS;
  logic              nWE;
  logic              nOE;

  // Requesters plus tri-state driver side
  modport master (
    output Req, Wr, Addr0, Addr1, WData0, WData1, BusData,
    input  Done, RData, Busy, nWRITE, DrvData, ExtAddr, nCS, nWE, nOE
  );

  // Controller side
  modport slave (
    input  Req, Wr, Addr0, Addr1, WData0, WData1, BusData,
    output Done, RData, Busy, nWRITE, DrvData, ExtAddr, nCS, nWE, nOE
  );
endinterface

// File: rtl/bus_access_controller.sv
// bus_access_controller: shares the external 16-bit bus between requester 0
// (voice engine) and requester 1 (control/config). Each access runs
// SETUP -> ACCESS -> TURN -> IDLE with fixed cycle counts; all outputs registered.
// Optional build macro BUSCTRL_FIXED_PRIO_EN: requester 0 always wins contention
// (no round-robin pointer). Default: round-robin.
module bus_access_controller #(
  parameter int ADDR_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int TURN_CYC   = 1
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  bus_access_controller_if.slave  bus,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    TURN   = 2'd3
  } state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ACCESS_LAST = 4'(ACCESS_CYC - 1);
  localparam logic [3:0] TURN_LAST   = 4'(TURN_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       drv_q, drv_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [1:0]        done_q, done_d;
  logic              busy_q, busy_d;
  logic              ncs_q, ncs_d;
  logic              nwrite_q, nwrite_d;
  logic              nwe_q, nwe_d;
  logic              noe_q, noe_d;
  logic              in_cs;
  logic              gnt_sel;

`ifdef BUSCTRL_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks
  assign gnt_sel = bus.Req[0] ? 1'b0 : 1'b1;
`else
  logic ptr_q;

  // Contention goes to the pointer; a lone request goes to its owner
  assign gnt_sel = (bus.Req == 2'b11) ? ptr_q : (bus.Req[0] ? 1'b0 : 1'b1);

  // Pointer always moves to the requester that was not just granted
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ptr_q <= 1'b0;
    end else if (state_q == IDLE && bus.Req != 2'b00) begin
      ptr_q <= ~gnt_sel;
    end
  end
`endif

  // Phase sequencing, request latching and next values of registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    drv_d   = drv_q;
    rdata_d = rdata_q;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.Req != 2'b00) begin
          gnt_d   = gnt_sel;
          wr_d    = bus.Wr[gnt_sel];
          addr_d  = gnt_sel ? bus.Addr1 : bus.Addr0;
          if (bus.Wr[gnt_sel]) begin
            drv_d = gnt_sel ? bus.WData1 : bus.WData0;
          end
          state_d = SETUP;
          cnt_d   = 4'd0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACCESS: begin
        if (cnt_q == ACCESS_LAST) begin
          state_d        = TURN;
          cnt_d          = 4'd0;
          done_d[gnt_q]  = 1'b1;
          if (!wr_q) begin
            rdata_d = bus.BusData;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      TURN: begin
        // Always pass through one IDLE cycle so a requester can drop Req after Done
        if (cnt_q == TURN_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Strobes follow the phase being entered; the FPGA drives only during a write's SETUP/ACCESS
    in_cs    = (state_d == SETUP) || (state_d == ACCESS);
    busy_d   = (state_d != IDLE);
    ncs_d    = ~in_cs;
    nwrite_d = ~(in_cs & wr_d);
    nwe_d    = ~((state_d == ACCESS) & wr_d);
    noe_d    = ~((state_d == ACCESS) & ~wr_d);
  end

  // State, latched request and output registers; reset releases the bus at once
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      drv_q    <= 16'h0000;
      rdata_q  <= 16'h0000;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
      ncs_q    <= 1'b1;
      nwrite_q <= 1'b1;
      nwe_q    <= 1'b1;
      noe_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      drv_q    <= drv_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ncs_q    <= ncs_d;
      nwrite_q <= nwrite_d;
      nwe_q    <= nwe_d;
      noe_q    <= noe_d;
    end
  end

  assign bus.Done    = done_q;
  assign bus.RData   = rdata_q;
  assign bus.Busy    = busy_q;
  assign bus.nWRITE  = nwrite_q;
  assign bus.DrvData = drv_q;
  assign bus.ExtAddr = addr_q;
  assign bus.nCS     = ncs_q;
  assign bus.nWE     = nwe_q;
  assign bus.nOE     = noe_q;
  assign state_o     = state_q;

endmodule
